// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage feeding the ALU.
// Each instruction word is decoded into {a, b, op, rd, illegal} and queued
// in a 2-entry skid buffer (main + skid) behind a valid/ready handshake.
// in_ready and all out_* signals come straight from flops, so there is no
// combinational path from out_ready back to in_ready.
//
// state | meaning
// EMPTY | nothing buffered, out_valid=0, in_ready=1
// ONE   | main holds the beat on out_*, skid free, in_ready=1
// FULL  | main and skid both hold beats, in_ready=0
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [OP_W-1:0] out_op,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic            illegal;
    } issue_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    issue_t dec;
    issue_t main_q;
    issue_t skid_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt_i;
    logic [XLEN-1:0] shamt_r;
    logic            in_fire;
    logic            out_fire;

    // rs1 index is resolved by the register file upstream; only its data is used here
    logic rs1_field_unused;
    assign rs1_field_unused = ^in_instr[19:15];

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign alt     = in_instr[30];
    assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u   = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign shamt_i = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign shamt_r = {{(XLEN-5){1'b0}}, in_rs2[4:0]};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Combinational decode of the incoming beat into ALU operands and op
    always_comb begin
        dec         = '0;
        dec.op      = OP_ADD;
        dec.rd      = in_instr[11:7];
        dec.illegal = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec.a = in_rs1;
                dec.b = in_rs2;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    dec.illegal = 1'b1;
                end else if (alt && funct3 != 3'b000 && funct3 != 3'b101) begin
                    dec.illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: dec.op = alt ? OP_SUB : OP_ADD;
                        3'b001: begin dec.op = OP_SLL; dec.b = shamt_r; end
                        3'b010: dec.op = OP_SLT;
                        3'b011: dec.op = OP_SLTU;
                        3'b101: begin dec.op = alt ? OP_SRA : OP_SRL; dec.b = shamt_r; end
                        3'b110: dec.op = OP_OR;
                        3'b111: dec.op = OP_AND;
                        default: dec.illegal = 1'b1;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                dec.a = in_rs1;
                dec.b = imm_i;
                case (funct3)
                    3'b000: dec.op = OP_ADD;
                    3'b010: dec.op = OP_SLT;
                    3'b011: dec.op = OP_SLTU;
                    3'b110: dec.op = OP_OR;
                    3'b111: dec.op = OP_AND;
                    3'b001: begin
                        dec.op = OP_SLL;
                        dec.b  = shamt_i;
                        if (funct7 != 7'b0000000) dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        dec.b = shamt_i;
                        if (funct7 == 7'b0000000)      dec.op = OP_SRL;
                        else if (funct7 == 7'b0100000) dec.op = OP_SRA;
                        else                           dec.illegal = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.a = '0;
                dec.b = imm_u;
            end
            OPC_AUIPC: begin
                dec.a = in_pc;
                dec.b = imm_u;
            end
            OPC_LOAD: begin
                dec.a = in_rs1;
                dec.b = imm_i;
            end
            OPC_STORE: begin
                dec.a  = in_rs1;
                dec.b  = imm_s;
                dec.rd = 5'd0;
            end
            OPC_BRANCH: begin
                dec.a  = in_rs1;
                dec.b  = in_rs2;
                dec.rd = 5'd0;
                case (funct3)
                    3'b000, 3'b001: dec.op = OP_SUB;
                    3'b100, 3'b101: dec.op = OP_SLT;
                    3'b110, 3'b111: dec.op = OP_SLTU;
                    default:        dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        // illegal beats still flow in order, but carry no operands
        if (dec.illegal) begin
            dec.a  = '0;
            dec.b  = '0;
            dec.op = OP_ADD;
            dec.rd = 5'd0;
        end
    end

    // Skid-buffer FSM; in_ready and out_valid are registered alongside state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q    <= dec;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= dec;
                    end else if (in_fire) begin
                        skid_q   <= dec;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_op      = main_q.op;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of decode, skid buffering, flush and reset.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_op;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;

    alu_issue_stage #(.XLEN(32), .OP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [4:0] rd, input logic ill);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".a"}, out_a, a);
        chk({tag, ".b"}, out_b, b);
        chk({tag, ".op"}, 32'(out_op), 32'(op));
        chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    // present one beat, let one rising edge take it, then withdraw it
    task automatic send(input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.a", out_a, 32'd0);
        chk("rst.b", out_b, 32'd0);
        chk("rst.op", 32'(out_op), 32'd0);
        chk("rst.rd", 32'(out_rd), 32'd0);
        chk("rst.illegal", 32'(out_illegal), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;

        // decode map, one beat per cycle with the ALU always ready
        send(I_ADD, 32'd5, 32'd7, 32'd0);
        chk_beat("add", 32'd5, 32'd7, 4'd0, 5'd3, 1'b0);
        send(32'h40335293, 32'h80000000, 32'd0, 32'd0);
        chk_beat("srai", 32'h80000000, 32'd3, 4'd6, 5'd5, 1'b0);
        send(32'hFFF00093, 32'd0, 32'd0, 32'd0);
        chk_beat("addi", 32'd0, 32'hFFFFFFFF, 4'd0, 5'd1, 1'b0);
        send(32'h00001117, 32'd9, 32'd9, 32'h100);
        chk_beat("auipc", 32'h100, 32'h1000, 4'd0, 5'd2, 1'b0);
        send(32'h0020C1B3, 32'd5, 32'd7, 32'd0);
        chk_beat("xor", 32'd0, 32'd0, 4'd0, 5'd0, 1'b1);
        send(32'h40208233, 32'd20, 32'd6, 32'd0);
        chk_beat("sub", 32'd20, 32'd6, 4'd1, 5'd4, 1'b0);
        send(32'h0020C063, 32'd11, 32'd12, 32'd0);
        chk_beat("blt", 32'd11, 32'd12, 4'd8, 5'd0, 1'b0);
        send(32'h0020A423, 32'h1000, 32'd3, 32'd0);
        chk_beat("sw", 32'h1000, 32'd8, 4'd0, 5'd0, 1'b0);
        send(32'h123453B7, 32'd1, 32'd1, 32'd0);
        chk_beat("lui", 32'd0, 32'h12345000, 4'd0, 5'd7, 1'b0);
        send(32'h40031293, 32'd1, 32'd1, 32'd0);
        chk_beat("slli_bad", 32'd0, 32'd0, 4'd0, 5'd0, 1'b1);
        send(32'h0020A063, 32'd1, 32'd1, 32'd0);
        chk_beat("br010", 32'd0, 32'd0, 4'd0, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("drain.valid", 32'(out_valid), 32'd0);

        // three back-to-back beats against a stalled ALU
        out_ready = 1'b0;
        send(I_ADD, 32'd1, 32'd1, 32'd0);
        chk("stall1.in_ready", 32'(in_ready), 32'd1);
        chk("stall1.a", out_a, 32'd1);
        send(I_ADD, 32'd2, 32'd2, 32'd0);
        chk("stall2.in_ready", 32'(in_ready), 32'd0);
        chk("stall2.a", out_a, 32'd1);
        in_valid = 1'b1;
        in_instr = I_ADD;
        in_rs1   = 32'd3;
        in_rs2   = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("held.in_ready", 32'(in_ready), 32'd0);
        chk("held.valid", 32'(out_valid), 32'd1);
        chk("held.a", out_a, 32'd1);
        chk("held.b", out_b, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rel1.a", out_a, 32'd2);
        chk("rel1.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rel2.valid", 32'(out_valid), 32'd1);
        chk("rel2.a", out_a, 32'd3);
        chk("rel2.b", out_b, 32'd3);
        @(posedge clk);
        #1;
        chk("rel3.valid", 32'(out_valid), 32'd0);

        // flush with a full buffer
        out_ready = 1'b0;
        send(I_ADD, 32'd4, 32'd4, 32'd0);
        send(I_ADD, 32'd5, 32'd5, 32'd0);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);

        // flush beats a same-cycle input transfer
        send(I_ADD, 32'd6, 32'd6, 32'd0);
        chk("one.valid", 32'(out_valid), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_rs1   = 32'd7;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flushin.valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("flushin.dropped", 32'(out_valid), 32'd0);

        // asynchronous reset in the middle of a stall
        send(I_ADD, 32'd8, 32'd8, 32'd0);
        chk("prerst.valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.a", out_a, 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(32'h40208233, 32'd9, 32'd4, 32'd0);
        chk_beat("post_rst", 32'd9, 32'd4, 4'd1, 5'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
